brick_scan_ctrl: RTL

BRICK_SCAN_CTRL -- requirements
Module: brick_scan_ctrl

---
 rtl/brick_pkg.sv | 20 ++
 rtl/brick_overlap.sv | 29 ++
 rtl/brick_scan_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/brick_pkg.sv
// Shared defaults, brick count and state encoding for the brick scan controller.
package brick_pkg;

  localparam int ROWS_DEF    = 3;
  localparam int COLS_DEF    = 8;
  localparam int BRICK_W_DEF = 80;
  localparam int BRICK_H_DEF = 50;
  localparam int BALL_R_DEF  = 3;

  localparam int NUM_BRICKS  = ROWS_DEF * COLS_DEF;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FRAME = 3'd1,
    SCAN       = 3'd2,
    UPDATE     = 3'd3,
    WIN        = 3'd4
  } state_t;

endpackage

// File: rtl/brick_overlap.sv
// Combinational box test between the latched ball and one brick, given as row/column.
module brick_overlap #(
  parameter int BRICK_W = 80,
  parameter int BRICK_H = 50,
  parameter int BALL_R  = 3,
  parameter int CW      = 3,
  parameter int RW      = 2
) (
  input  logic [CW-1:0] col,
  input  logic [RW-1:0] row,
  input  logic [9:0]    bx,
  input  logic [9:0]    by,
  output logic          overlap
);

  logic [10:0] x0, y0, bxe, bye;

  // Widened to 11 bits so the ball-radius and brick-extent sums cannot wrap
  assign x0  = 11'(col) * 11'(BRICK_W);
  assign y0  = 11'(row) * 11'(BRICK_H);
  assign bxe = {1'b0, bx};
  assign bye = {1'b0, by};

  assign overlap = (bxe + 11'(BALL_R) > x0)
                && (bxe < x0 + 11'(BRICK_W + BALL_R))
                && (bye + 11'(BALL_R) > y0)
                && (bye < y0 + 11'(BRICK_H + BALL_R));

endmodule

// File: rtl/brick_scan_ctrl.sv
// Per-frame brick collision scanner: one brick per cycle, at most one strike per frame.
//   state      | meaning
//   IDLE       | waiting for start (active low)
//   WAIT_FRAME | waiting for frame_tick to latch the ball
//   SCAN       | testing brick idx against the latched ball
//   UPDATE     | strike recorded, bounce pulse
//   WIN        | every brick destroyed, locked until rst
module brick_scan_ctrl
  import brick_pkg::*;
#(
  parameter int ROWS    = ROWS_DEF,
  parameter int COLS    = COLS_DEF,
  parameter int BRICK_W = BRICK_W_DEF,
  parameter int BRICK_H = BRICK_H_DEF,
  parameter int BALL_R  = BALL_R_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 frame_tick,
  input  logic [9:0]           ballx,
  input  logic [9:0]           bally,
  output logic [ROWS*COLS-1:0] hit,
  output logic                 bounce,
  output logic [4:0]           hit_idx,
  output logic [4:0]           score,
  output logic                 win,
  output logic                 busy,
  output logic                 overrun
);

  localparam int NB = ROWS * COLS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  state_t          state, state_nx;
  logic [9:0]      bx_q, by_q;
  logic [4:0]      idx;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic            overlap;
  logic            strike;
  logic            last;

  brick_overlap #(
    .BRICK_W (BRICK_W),
    .BRICK_H (BRICK_H),
    .BALL_R  (BALL_R),
    .CW      (CW),
    .RW      (RW)
  ) u_overlap (
    .col     (col),
    .row     (row),
    .bx      (bx_q),
    .by      (by_q),
    .overlap (overlap)
  );

  assign strike = (state == SCAN) && overlap && !hit[idx];
  assign last   = (idx == 5'(NB - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    bounce   = 1'b0;
    busy     = 1'b0;
    win      = 1'b0;
    case (state)
      IDLE:       if (!start) state_nx = WAIT_FRAME;
      WAIT_FRAME: if (frame_tick) state_nx = SCAN;
      SCAN: begin
        busy = 1'b1;
        if (strike)    state_nx = UPDATE;
        else if (last) state_nx = WAIT_FRAME;
      end
      UPDATE: begin
        busy     = 1'b1;
        bounce   = 1'b1;
        state_nx = (score == 5'(NB)) ? WIN : WAIT_FRAME;
      end
      WIN:     win = 1'b1;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bx_q    <= '0;
      by_q    <= '0;
      idx     <= '0;
      row     <= '0;
      col     <= '0;
      hit     <= '0;
      hit_idx <= '0;
      score   <= '0;
      overrun <= 1'b0;
    end else begin
      if (frame_tick && busy) overrun <= 1'b1;
      if (state == WAIT_FRAME && frame_tick) begin
        bx_q <= ballx;
        by_q <= bally;
        idx  <= '0;
        row  <= '0;
        col  <= '0;
      end else if (state == SCAN) begin
        if (strike) begin
          hit[idx] <= 1'b1;
          hit_idx  <= idx;
          score    <= score + 5'd1;
        end
        // Row/column walk alongside idx so no divide is needed
        idx <= idx + 5'd1;
        if (col == CW'(COLS - 1)) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule
